deser_arbiter: RTL
==================

DESER_ARBITER -- requirements
Module: deser_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, meaning number of serial sources sharing one deserializer (range 2..8).
REQ-002 SHALL have parameter IDX_W, default $clog2(N_SRC), meaning the source-index width.
REQ-003 SHALL have port clk_100mhz, input, 1, the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port src_req, input, N_SRC, where source i requests a byte slot.
REQ-006 SHALL have port src_data, input, N_SRC, the serial bit from source i.
REQ-007 SHALL have port src_valid, input, N_SRC, which qualifies src_data[i].
REQ-008 SHALL have port src_grant, output, N_SRC, a one-hot grant that is all-zero when no source is granted.
REQ-009 SHALL have ports des_data_in and des_write_in, output, 1 each, driving the deserializer's bit and write-strobe inputs.
REQ-010 SHALL have port des_ack_in, output, 1, the deserializer consume acknowledge.
REQ-011 SHALL have ports des_data_out (input, 8), des_data_ready (input, 1) and des_status (input, 1), which are the deserializer outputs.
REQ-012 SHALL have ports byte_out (output, 8), byte_src (output, IDX_W) and byte_valid (output, 1), forming the delivered byte, its source tag and its valid flag.
REQ-013 SHALL have port byte_ack, input, 1, the consumer accept signal.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, WAIT_RDY, DELIVER and ACK.
REQ-015 IDLE SHALL move to SHIFT when any src_req bit is 1, granting the first requester at or after rr_ptr in round-robin order and registering that grant in the same transition.
REQ-016 SHIFT SHALL drive des_data_in = src_data[g] and des_write_in = src_valid[g] & des_status, combinationally, where g is the granted index.
REQ-017 SHIFT SHALL increment a 3-bit bit_cnt on every cycle with des_write_in=1, and SHALL go to WAIT_RDY on the write cycle where bit_cnt==7.
REQ-018 The grant SHALL be held for the full 8 bits regardless of src_req; src_valid gaps stall counting only.
REQ-019 WAIT_RDY SHALL go to DELIVER when des_data_ready=1, which is expected 1 cycle after the 8th write; des_write_in SHALL be 0 in this state.
REQ-020 On entering DELIVER, the block SHALL register byte_out <= des_data_out and byte_src <= g, then hold byte_valid=1 until byte_ack=1.
REQ-021 A DELIVER cycle with byte_ack=1 SHALL go to ACK; ACK SHALL assert des_ack_in=1 for exactly one cycle and then return to IDLE.
REQ-022 On leaving ACK, the block SHALL set rr_ptr = (g+1) mod N_SRC, deassert src_grant and clear bit_cnt.
REQ-023 Two consecutive grants SHALL be separated by at least one IDLE cycle.
REQ-024 If all src_req bits are 1, grants SHALL rotate 0,1,2,3,0,...; a single requester SHALL be re-granted on every slot.
REQ-025 byte_out and byte_src SHALL remain stable while byte_valid=1.
REQ-026 des_write_in and des_ack_in SHALL never both be 1 in the same cycle.

Reset
REQ-027 When reset=1 at a clock edge, the block SHALL set state=IDLE, rr_ptr=0, bit_cnt=0, src_grant=0, byte_valid=0, byte_out=0, byte_src=0, des_ack_in=0 and des_write_in=0.
REQ-028 Reset asserted mid-byte SHALL discard the partial byte without delivery; the deserializer shares the same reset.
REQ-029 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-030 With DESER_ARB_STATS_EN defined, the block SHALL add input stat_sel (IDX_W) and output stat_count (16), plus one 16-bit count per source.
REQ-031 With DESER_ARB_STATS_EN defined, each count SHALL increment on the ACK cycle of its source, wrap from 0xFFFF to 0, be cleared by reset, and be presented on stat_count as stat_count = count[stat_sel] combinationally.
REQ-032 Without DESER_ARB_STATS_EN, the block SHALL omit those ports and registers, and all other behaviour SHALL be identical.

Structure
REQ-033 Package deser_arb_pkg SHALL hold the FSM state enum (arb_state_t), BYTE_W=8, BITS_PER_BYTE=8 and STAT_W=16.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs: req vector and rr_ptr; outputs: one-hot grant and index), which is combinational.
REQ-035 The deserializer itself SHALL NOT be instantiated inside deser_arbiter; it is connected at the level above.

Verification
REQ-036 Single source: src_req=0001 with bits 1,0,1,0,0,1,0,1 sent with src_valid=1 -> byte_out=0xA5, byte_src=0, byte_valid asserted 2 cycles after the 8th write.
REQ-037 Round-robin: src_req=1111 held for 4 bytes -> byte_src sequence 0,1,2,3, and src_grant is never multi-hot.
REQ-038 Stall: src_valid toggles 1,0,1,0 while sending 0x3C -> byte_out=0x3C, and bit_cnt advances only on valid cycles.
REQ-039 Backpressure: byte_ack held 0 for 10 cycles -> byte_valid stays 1, byte_out is stable, des_ack_in=0, and no new grant is issued.
REQ-040 Reset after 5 bits of a byte -> next cycle all outputs are 0 and state is IDLE; a new byte 0xFF from source 2 is then delivered correctly.
REQ-041 With DESER_ARB_STATS_EN: 3 bytes from source 1 -> stat_sel=1 gives stat_count=3; count preset to 0xFFFF followed by 1 byte -> 0.

Source files
------------

// File: rtl/deser_arb_pkg.sv
// Shared types and constants for the deserializer arbiter.
// Holds the FSM state enum and the byte/bit/statistics widths.
package deser_arb_pkg;
    localparam int BYTE_W        = 8;
    localparam int BITS_PER_BYTE = 8;
    localparam int CNT_W         = $clog2(BITS_PER_BYTE);
    localparam int STAT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WAIT_RDY,
        DELIVER,
        ACK
    } arb_state_t;
endpackage

// File: rtl/deser_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
// Ports: req (request vector), rr_ptr (start index), grant (one-hot), idx.
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_SRC-1:0] grant,
    output logic [IDX_W-1:0] idx
);
    int c;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = 0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            c = (int'(rr_ptr) + k) % N_SRC;
            if (req[c]) begin
                grant    = '0;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end
endmodule

// File: rtl/deser_arbiter.sv
// Shares one external deserializer between N_SRC serial sources, one byte per grant.
// Ports: src_* sources, des_* deserializer side, byte_* delivered byte; optional
// stat_sel/stat_count per-source byte counters when DESER_ARB_STATS_EN is defined.
module deser_arbiter
    import deser_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic [N_SRC-1:0]  src_req,
    input  logic [N_SRC-1:0]  src_data,
    input  logic [N_SRC-1:0]  src_valid,
    output logic [N_SRC-1:0]  src_grant,
    output logic              des_data_in,
    output logic              des_write_in,
    output logic              des_ack_in,
    input  logic [BYTE_W-1:0] des_data_out,
    input  logic              des_data_ready,
    input  logic              des_status,
`ifdef DESER_ARB_STATS_EN
    input  logic [IDX_W-1:0]  stat_sel,
    output logic [STAT_W-1:0] stat_count,
`endif
    output logic [BYTE_W-1:0] byte_out,
    output logic [IDX_W-1:0]  byte_src,
    output logic              byte_valid,
    input  logic              byte_ack
);
    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] g;
    logic [CNT_W-1:0] bit_cnt;
    logic [N_SRC-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             any_req;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (src_req),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .idx    (pick_idx)
    );

    assign any_req = |src_req;

    always_comb begin
        des_data_in  = 1'b0;
        des_write_in = 1'b0;
        if (state == SHIFT) begin
            des_data_in  = src_data[g];
            des_write_in = src_valid[g] & des_status;
        end
    end

    assign des_ack_in = (state == ACK);
    assign byte_valid = (state == DELIVER);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (any_req) state_nxt = SHIFT;
            SHIFT:    if (des_write_in &&
                          bit_cnt == CNT_W'(BITS_PER_BYTE - 1))
                          state_nxt = WAIT_RDY;
            WAIT_RDY: if (des_data_ready) state_nxt = DELIVER;
            DELIVER:  if (byte_ack) state_nxt = ACK;
            ACK:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            g         <= '0;
            bit_cnt   <= '0;
            src_grant <= '0;
            byte_out  <= '0;
            byte_src  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                src_grant <= pick_grant;
                g         <= pick_idx;
            end
            if (des_write_in) bit_cnt <= bit_cnt + 1'b1;
            if (state == WAIT_RDY && des_data_ready) begin
                byte_out <= des_data_out;
                byte_src <= g;
            end
            if (state == ACK) begin
                rr_ptr    <= (g == IDX_W'(N_SRC - 1)) ? '0 : g + 1'b1;
                src_grant <= '0;
                bit_cnt   <= '0;
            end
        end
    end

`ifdef DESER_ARB_STATS_EN
    logic [STAT_W-1:0] stat_cnt [N_SRC];

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            for (int i = 0; i < N_SRC; i++) stat_cnt[i] <= '0;
        end else if (state == ACK) begin
            stat_cnt[g] <= stat_cnt[g] + STAT_W'(1);
        end
    end

    // Out-of-range selects (non power-of-two N_SRC) read as zero.
    assign stat_count = (int'(stat_sel) < N_SRC) ? stat_cnt[stat_sel] : '0;
`endif
endmodule
